// File: rtl/link_pair_scheduler.sv
// link_pair_scheduler
//   Powers up the two pair-group supply rails in order (1236, then 5478),
//   waits for them to settle, then round-robins bursts between two
//   requesters. Each grant alternates the pair group (LaneSel). A supply
//   drop while the rails are up forces FAULT. FAULT is left only through
//   IDLE, once Enable is deasserted.
//
// Ports
//   Clock100MhzP                   : single clock, rising edge
//   ResetN                         : synchronous, active-low reset
//   Enable                         : link enable
//   SupplyGood1236, SupplyGood5478 : rail-in-range indications
//   Req, Valid, Last [1:0]         : per-requester request / beat valid / final beat
//   SupplyOn1236, SupplyOn5478     : rail enables (registered)
//   Grant [1:0]                    : one-hot grant, or zero (registered)
//   Ready [1:0]                    : beat accept = Grant & Valid while in XFER
//   LaneSel                        : pair group of the current grant (0=1236, 1=5478)
//   Busy, Fault                    : state is XFER / state is FAULT (registered)
module link_pair_scheduler #(
  parameter int SETTLE_CYCLES = 16,
  parameter int PWR_TIMEOUT   = 64,
  parameter int BURST_MAX     = 8
) (
  input  logic       Clock100MhzP,
  input  logic       ResetN,
  input  logic       Enable,
  input  logic       SupplyGood1236,
  input  logic       SupplyGood5478,
  input  logic [1:0] Req,
  input  logic [1:0] Valid,
  input  logic [1:0] Last,
  output logic       SupplyOn1236,
  output logic       SupplyOn5478,
  output logic [1:0] Grant,
  output logic [1:0] Ready,
  output logic       LaneSel,
  output logic       Busy,
  output logic       Fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_PWR1236, S_PWR5478, S_SETTLE, S_ARB, S_XFER, S_FAULT
  } state_t;

  // One counter serves as the timeout, settle and beat counter. Only one of
  // these is live in any state, and the counter clears on every state change.
  localparam int CNT_MAX_A = (SETTLE_CYCLES > PWR_TIMEOUT) ? SETTLE_CYCLES : PWR_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > BURST_MAX) ? CNT_MAX_A : BURST_MAX;
  localparam int CW        = $clog2(CNT_MAX + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_idx_q, last_idx_d;    // index of the requester granted last
  logic          lane_hist_q, lane_hist_d;  // lane used by the most recent grant
  logic          lane_sel_q, lane_sel_d;
  logic          son1236_q, son1236_d;
  logic          son5478_q, son5478_d;
  logic          busy_q, busy_d;
  logic          fault_q, fault_d;

  logic supply_ok;
  logic gidx;
  logic beat_ok;
  logic beat_end;
  logic pick;

  always_comb begin
    supply_ok = SupplyGood1236 & SupplyGood5478;
    gidx      = grant_q[1];
    beat_ok   = (state_q == S_XFER) & Valid[gidx];
    beat_end  = beat_ok & (Last[gidx] | (cnt_q == CW'(BURST_MAX - 1)));
    // On a tie the requester not granted last wins.
    pick      = (Req == 2'b11) ? ~last_idx_q : Req[1];

    state_d     = state_q;
    grant_d     = grant_q;
    last_idx_d  = last_idx_q;
    lane_hist_d = lane_hist_q;

    case (state_q)
      S_IDLE: begin
        if (Enable) state_d = S_PWR1236;
      end
      S_PWR1236: begin
        if (!Enable)                              state_d = S_IDLE;
        else if (SupplyGood1236)                  state_d = S_PWR5478;
        else if (cnt_q == CW'(PWR_TIMEOUT - 1))   state_d = S_FAULT;
      end
      S_PWR5478: begin
        if (!Enable)                              state_d = S_IDLE;
        else if (SupplyGood5478)                  state_d = S_SETTLE;
        else if (cnt_q == CW'(PWR_TIMEOUT - 1))   state_d = S_FAULT;
      end
      S_SETTLE: begin
        if (!supply_ok)                           state_d = S_FAULT;
        else if (!Enable)                         state_d = S_IDLE;
        else if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = S_ARB;
      end
      S_ARB: begin
        if (!supply_ok)      state_d = S_FAULT;
        else if (!Enable)    state_d = S_IDLE;
        else if (Req != 2'b00) begin
          state_d     = S_XFER;
          grant_d     = pick ? 2'b10 : 2'b01;
          last_idx_d  = pick;
          lane_hist_d = ~lane_hist_q;
        end
      end
      S_XFER: begin
        // Supply loss beats burst end; Enable only chooses where a finished
        // burst goes, so a burst in flight always completes.
        if (!supply_ok)    state_d = S_FAULT;
        else if (beat_end) state_d = Enable ? S_ARB : S_IDLE;
      end
      S_FAULT: begin
        if (!Enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Grant is held only while in XFER, which also gives the idle ARB cycle
    // between consecutive grants.
    if (state_d != S_XFER) grant_d = 2'b00;

    if (state_d != state_q)
      cnt_d = '0;
    else if (state_q == S_XFER)
      cnt_d = cnt_q + CW'(beat_ok);
    else if (state_q inside {S_PWR1236, S_PWR5478, S_SETTLE})
      cnt_d = cnt_q + CW'(1);
    else
      cnt_d = cnt_q;

    // Outputs are registered images of the state being entered.
    son1236_d  = state_d inside {S_PWR1236, S_PWR5478, S_SETTLE, S_ARB, S_XFER};
    son5478_d  = state_d inside {S_PWR5478, S_SETTLE, S_ARB, S_XFER};
    busy_d     = (state_d == S_XFER);
    fault_d    = (state_d == S_FAULT);
    lane_sel_d = (state_d == S_XFER) ? lane_hist_d : 1'b0;
  end

  always_ff @(posedge Clock100MhzP) begin
    if (!ResetN) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      grant_q     <= 2'b00;
      last_idx_q  <= 1'b1;  // requester 0 wins the first tie
      lane_hist_q <= 1'b1;  // first grant toggles to lane 0
      lane_sel_q  <= 1'b0;
      son1236_q   <= 1'b0;
      son5478_q   <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      last_idx_q  <= last_idx_d;
      lane_hist_q <= lane_hist_d;
      lane_sel_q  <= lane_sel_d;
      son1236_q   <= son1236_d;
      son5478_q   <= son5478_d;
      busy_q      <= busy_d;
      fault_q     <= fault_d;
    end
  end

  // Ready is the only output that is combinational in an input (Valid).
  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign Ready[gi] = grant_q[gi] & Valid[gi] & busy_q;
  end

  assign SupplyOn1236 = son1236_q;
  assign SupplyOn5478 = son5478_q;
  assign Grant        = grant_q;
  assign LaneSel      = lane_sel_q;
  assign Busy         = busy_q;
  assign Fault        = fault_q;

endmodule

// File: tb/tb_link_pair_scheduler.sv
// Testbench for link_pair_scheduler: a table of single-cycle vectors for the
// power-up/IDLE/FAULT transitions, hand-written sequences for the multi-cycle
// cases (bring-up, timeout, round-robin, burst cap, supply loss, reset
// mid-burst), and a randomized run checked against a behavioural model.
module tb_link_pair_scheduler;

  localparam int SETTLE = 16;
  localparam int TMO    = 64;
  localparam int BMAX   = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       good1236, good5478;
  logic [1:0] req, valid, last;
  logic       son1236, son5478;
  logic [1:0] grant, ready;
  logic       lane_sel, busy, fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  link_pair_scheduler #(
    .SETTLE_CYCLES(SETTLE), .PWR_TIMEOUT(TMO), .BURST_MAX(BMAX)
  ) dut (
    .Clock100MhzP  (clk),
    .ResetN        (rst_n),
    .Enable        (enable),
    .SupplyGood1236(good1236),
    .SupplyGood5478(good5478),
    .Req           (req),
    .Valid         (valid),
    .Last          (last),
    .SupplyOn1236  (son1236),
    .SupplyOn5478  (son5478),
    .Grant         (grant),
    .Ready         (ready),
    .LaneSel       (lane_sel),
    .Busy          (busy),
    .Fault         (fault)
  );

  logic [8:0] dut_outs;
  assign dut_outs = {son1236, son5478, grant, ready, lane_sel, busy, fault};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; good1236 = 1'b0; good5478 = 1'b0;
    req = 2'b00; valid = 2'b00; last = 2'b00;
    tick();
    tick();
    chk("reset_outputs", 32'(dut_outs), 32'd0);
    rst_n = 1'b1;
  endtask

  // Starts right after reset release. Supplies come good at cycle 3; ends in
  // cycle 21, the first ARB cycle. Req is presented from the start, so a
  // premature ARB would show up as Busy at cycle 21.
  task automatic bring_up(input logic [1:0] req_in);
    enable = 1'b1; good1236 = 1'b0; good5478 = 1'b0; req = req_in;
    tick();                                            // cycle 1
    chk("bringup_c1_on1236", 32'(son1236), 32'd1);
    chk("bringup_c1_on5478", 32'(son5478), 32'd0);
    tick(); tick();                                    // cycle 3
    chk("bringup_c3_on5478", 32'(son5478), 32'd0);
    good1236 = 1'b1; good5478 = 1'b1;
    tick();                                            // cycle 4
    chk("bringup_c4_on5478", 32'(son5478), 32'd1);
    for (int c = 5; c <= 21; c++) tick();              // cycle 21
    chk("bringup_c21_busy", 32'(busy), 32'd0);
    chk("bringup_c21_fault", 32'(fault), 32'd0);
    chk("bringup_c21_on", 32'({son1236, son5478}), 32'd3);
    $display("bring-up done req=%b outs=%b", req_in, dut_outs);
  endtask

  // ---------------- behavioural reference model ----------------
  // mode: 0 idle, 1 rail 1236 coming up, 2 rail 5478 coming up, 3 settling,
  // 4 arbitrating, 5 transferring, 6 fault
  int m_mode, m_el, m_beats, m_who, m_prev, m_lane;

  task automatic m_reset();
    m_mode = 0; m_el = 0; m_beats = 0; m_who = 0; m_prev = 1; m_lane = 1;
  endtask

  function automatic logic [8:0] m_outs(input logic [1:0] v);
    logic       s1, s2, ln, bz, ft;
    logic [1:0] g;
    s1 = (m_mode >= 1) && (m_mode <= 5);
    s2 = (m_mode >= 2) && (m_mode <= 5);
    bz = (m_mode == 5);
    ft = (m_mode == 6);
    g  = bz ? ((m_who == 1) ? 2'b10 : 2'b01) : 2'b00;
    ln = bz ? (m_lane == 1) : 1'b0;
    return {s1, s2, g, g & v, ln, bz, ft};
  endfunction

  task automatic m_step(input logic r_n, input logic en, input logic g1, input logic g2,
                        input logic [1:0] rq, input logic [1:0] v, input logic [1:0] l);
    int  nxt;
    logic ok;
    if (!r_n) begin
      m_reset();
      return;
    end
    nxt = m_mode;
    ok  = g1 && g2;
    case (m_mode)
      0: if (en) nxt = 1;
      1: if (!en) nxt = 0; else if (g1) nxt = 2; else if (m_el + 1 >= TMO) nxt = 6;
      2: if (!en) nxt = 0; else if (g2) nxt = 3; else if (m_el + 1 >= TMO) nxt = 6;
      3: if (!ok) nxt = 6; else if (!en) nxt = 0; else if (m_el + 1 >= SETTLE) nxt = 4;
      4: if (!ok) nxt = 6;
         else if (!en) nxt = 0;
         else if (rq != 2'b00) begin
           m_who   = (rq == 2'b11) ? (1 - m_prev) : (rq[1] ? 1 : 0);
           m_prev  = m_who;
           m_lane  = 1 - m_lane;
           m_beats = 0;
           nxt     = 5;
         end
      5: if (!ok) nxt = 6;
         else if (v[m_who]) begin
           m_beats++;
           if (l[m_who] || m_beats == BMAX) nxt = en ? 4 : 0;
         end
      default: if (!en) nxt = 0;
    endcase
    m_el   = (nxt == m_mode) ? m_el + 1 : 0;
    m_mode = nxt;
  endtask

  // ---------------- single-cycle vector table ----------------
  typedef struct packed {
    logic en, g1, g2;
    logic e_s1, e_s2, e_fault;
  } vec_t;
  vec_t vecs[16];

  logic [1:0] rr_grant[7];
  logic       rr_lane[7];
  logic [1:0] rr_last[7];

  initial begin
    int nready;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};  // IDLE holds
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};  // -> PWR1236
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};  // Enable drop -> IDLE
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};  // -> PWR1236
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};  // -> PWR5478
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};  // Enable drop -> IDLE
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};  // -> PWR1236
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};  // -> PWR5478
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};  // -> SETTLE
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};  // rail loss -> FAULT
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};  // FAULT holds with Enable
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};  // -> IDLE
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};  // -> PWR1236
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};  // -> PWR5478
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};  // -> SETTLE
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};  // Enable drop in SETTLE -> IDLE

    rr_grant[0] = 2'b01; rr_grant[1] = 2'b01; rr_grant[2] = 2'b00; rr_grant[3] = 2'b10;
    rr_grant[4] = 2'b10; rr_grant[5] = 2'b00; rr_grant[6] = 2'b01;
    rr_lane[0] = 1'b0; rr_lane[1] = 1'b0; rr_lane[2] = 1'b0; rr_lane[3] = 1'b1;
    rr_lane[4] = 1'b1; rr_lane[5] = 1'b0; rr_lane[6] = 1'b0;
    rr_last[0] = 2'b00; rr_last[1] = 2'b11; rr_last[2] = 2'b00; rr_last[3] = 2'b00;
    rr_last[4] = 2'b11; rr_last[5] = 2'b00; rr_last[6] = 2'b00;

    // ---- table ----
    do_reset();
    for (int i = 0; i < 16; i++) begin
      enable = vecs[i].en; good1236 = vecs[i].g1; good5478 = vecs[i].g2;
      tick();
      chk($sformatf("table_row%0d", i),
          32'({son1236, son5478, fault, busy, grant}),
          32'({vecs[i].e_s1, vecs[i].e_s2, vecs[i].e_fault, 1'b0, 2'b00}));
      $display("table row %0d en=%b g=%b%b outs=%b", i, vecs[i].en, vecs[i].g1, vecs[i].g2, dut_outs);
    end

    // ---- bring-up, then first grant one cycle after ARB ----
    do_reset();
    valid = 2'b01;
    bring_up(2'b01);
    tick();                                            // cycle 22
    chk("bringup_grant", 32'(grant), 32'd1);
    chk("bringup_lane", 32'(lane_sel), 32'd0);

    // ---- supply timeout ----
    do_reset();
    enable = 1'b1;
    tick();                                            // cycle 1, PWR1236
    for (int c = 2; c <= 64; c++) tick();              // cycle 64, last PWR1236 cycle
    chk("timeout_c64_fault", 32'(fault), 32'd0);
    chk("timeout_c64_on1236", 32'(son1236), 32'd1);
    tick();                                            // cycle 65
    chk("timeout_fault", 32'(fault), 32'd1);
    chk("timeout_supply_off", 32'({son1236, son5478}), 32'd0);
    enable = 1'b0;
    tick();
    chk("timeout_to_idle", 32'(dut_outs), 32'd0);
    $display("timeout sequence outs=%b", dut_outs);

    // ---- round-robin with 2-beat bursts ----
    do_reset();
    valid = 2'b11; last = 2'b00;
    bring_up(2'b11);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("rr_grant%0d", k), 32'(grant), 32'(rr_grant[k]));
      chk($sformatf("rr_lane%0d", k), 32'(lane_sel), 32'(rr_lane[k]));
      chk($sformatf("rr_ready%0d", k), 32'(ready), 32'(rr_grant[k]));
      $display("rr cycle %0d grant=%b lane=%b ready=%b", 22 + k, grant, lane_sel, ready);
      last = rr_last[k];
    end

    // ---- burst cap ----
    do_reset();
    valid = 2'b01; last = 2'b00;
    bring_up(2'b01);
    tick();                                            // cycle 22, XFER
    req = 2'b00;                                       // ignored during XFER
    nready = 0;
    for (int k = 0; k < 12; k++) begin
      if (ready[0]) nready++;
      tick();
    end
    chk("burstcap_ready_pulses", 32'(nready), 32'd8);
    chk("burstcap_back_to_arb", 32'({son1236, son5478, busy, fault, grant}), 32'b110000);
    $display("burst cap ready pulses=%0d", nready);

    // ---- supply loss mid-burst ----
    do_reset();
    valid = 2'b01; last = 2'b00;
    bring_up(2'b01);
    tick(); tick(); tick();                            // cycle 24, beat 3
    chk("loss_beat3_ready", 32'(ready), 32'd1);
    good5478 = 1'b0;
    tick();
    chk("loss_fault", 32'(fault), 32'd1);
    chk("loss_grant", 32'(grant), 32'd0);
    chk("loss_ready", 32'(ready), 32'd0);
    chk("loss_supply_off", 32'({son1236, son5478}), 32'd0);
    enable = 1'b0; good5478 = 1'b1;
    tick();
    chk("loss_to_idle", 32'(dut_outs), 32'd0);
    $display("supply loss sequence outs=%b", dut_outs);

    // ---- reset mid-burst ----
    do_reset();
    valid = 2'b01; last = 2'b00;
    bring_up(2'b01);
    tick(); tick();                                    // cycle 23, beat 2
    chk("rstmid_beat2_ready", 32'(ready), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rstmid_outputs", 32'(dut_outs), 32'd0);
    rst_n = 1'b1;
    bring_up(2'b01);
    tick();
    chk("rstmid_regrant", 32'(grant), 32'd1);
    chk("rstmid_lane", 32'(lane_sel), 32'd0);
    $display("reset mid-burst regrant=%b lane=%b", grant, lane_sel);

    // ---- randomized run against the model ----
    do_reset();
    m_reset();
    for (int n = 0; n < 4000; n++) begin
      rst_n    = ($urandom_range(0, 599) != 0);
      enable   = ($urandom_range(0, 79) != 0);
      good1236 = ($urandom_range(0, 249) != 0);
      good5478 = ($urandom_range(0, 249) != 0);
      req      = 2'($urandom_range(0, 3));
      valid    = 2'($urandom_range(0, 3));
      last     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      #1;
      chk($sformatf("random_cycle%0d", n), 32'(dut_outs), 32'(m_outs(valid)));
      m_step(rst_n, enable, good1236, good5478, req, valid, last);
      @(posedge clk);
      #1;
    end
    $display("random run of 4000 cycles complete");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/link_pair_scheduler.md
LINK_PAIR_SCHEDULER -- requirements
Module: link_pair_scheduler

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 16, giving the cycles to wait after both pair supplies report good.
REQ-002 The block SHALL have parameter PWR_TIMEOUT, default 64, giving the maximum cycles to wait for each SupplyGood.
REQ-003 The block SHALL have parameter BURST_MAX, default 8, giving the maximum beats per grant.
REQ-004 The block SHALL have port Clock100MhzP, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port ResetN, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port Enable, input, 1 bit: link enable.
REQ-007 The block SHALL have ports SupplyGood1236 and SupplyGood5478, input, 1 bit each: the V+/V- rail for that pair group is within range.
REQ-008 The block SHALL have ports Req, Valid and Last, input, 2 bits each, indexed by requester: request, beat valid, and final beat.
REQ-009 The block SHALL have ports SupplyOn1236 and SupplyOn5478, output, 1 bit each: rail enables.
REQ-010 The block SHALL have port Grant, output, 2 bits: one-hot grant, or zero.
REQ-011 The block SHALL have port Ready, output, 2 bits: beat accept, equal to Grant & Valid during XFER.
REQ-012 The block SHALL have port LaneSel, output, 1 bit: pair group for the current grant (0=1236, 1=5478).
REQ-013 The block SHALL have ports Busy and Fault, output, 1 bit each: the state is XFER, and the state is FAULT.

Function
REQ-014 The block SHALL implement the states IDLE, PWR1236, PWR5478, SETTLE, ARB, XFER and FAULT.
REQ-015 In IDLE, all outputs SHALL be 0; when Enable=1, the next state SHALL be PWR1236.
REQ-016 In PWR1236, SupplyOn1236=1; when SupplyGood1236=1, the next state SHALL be PWR5478.
REQ-017 In PWR1236, if PWR_TIMEOUT cycles pass without SupplyGood1236, the next state SHALL be FAULT.
REQ-018 In PWR5478, both SupplyOn outputs=1; when SupplyGood5478=1, the next state SHALL be SETTLE, with the same timeout to FAULT.
REQ-019 The timeout counter SHALL clear on every state entry.
REQ-020 In SETTLE, the block SHALL count SETTLE_CYCLES cycles, then go to ARB.
REQ-021 In ARB, if Req is nonzero, the block SHALL grant round-robin: the requester not granted last wins a tie; after reset, requester 0 has priority.
REQ-022 On the grant, Grant SHALL be registered, LaneSel SHALL toggle from its previous value (first grant after reset: LaneSel=0), and the next state SHALL be XFER.
REQ-023 In ARB, Grant SHALL be 0, so at least one idle cycle separates consecutive grants.
REQ-024 In XFER, each cycle with Ready[g]=1 SHALL increment the beat counter, which clears on XFER entry.
REQ-025 XFER SHALL end on an accepted beat with Last[g]=1, or on the BURST_MAX-th accepted beat, whichever comes first; the next state is ARB.
REQ-026 Valid=0 during XFER SHALL hold the state without timeout.
REQ-027 Req deassertion during XFER SHALL be ignored.
REQ-028 If Enable=0 in ARB or SETTLE, the next state SHALL be IDLE.
REQ-029 If Enable=0 in XFER, the burst SHALL complete and the block SHALL then go to IDLE instead of ARB.
REQ-030 If Enable=0 in PWR1236 or PWR5478, the next state SHALL be IDLE.
REQ-031 In SETTLE, ARB or XFER, if either SupplyGood input is 0, the next state SHALL be FAULT immediately, with Grant and Ready cleared the same edge.
REQ-032 Supply loss SHALL take priority over burst end and Enable.
REQ-033 In FAULT, SupplyOn=0, Grant=0 and Fault=1; the block SHALL leave FAULT only to IDLE, when Enable=0.
REQ-034 The block SHALL have no combinational path from Req to Grant.
REQ-035 Ready SHALL be the only output combinational in Valid.

Reset
REQ-036 When ResetN=0 at a clock edge, the state SHALL become IDLE.
REQ-037 On reset, all outputs SHALL be 0, all counters 0, the round-robin pointer SHALL favour requester 0, and the LaneSel history SHALL be 1 so the first grant uses lane 0.
REQ-038 Reset asserted mid-XFER SHALL drop Grant and Ready on that edge, with no burst completion.

Verification
REQ-039 The bench SHALL cover bring-up: Enable=1, SupplyGood1236 at cycle 3, SupplyGood5478 at cycle 3 -> SupplyOn1236 at cycle 1, SupplyOn5478 at cycle 4, ARB after 16 SETTLE cycles, Fault=0.
REQ-040 The bench SHALL cover supply timeout: SupplyGood1236 held 0 -> FAULT after 64 cycles in PWR1236, SupplyOn=0; Enable=0 -> IDLE.
REQ-041 The bench SHALL cover round-robin: Req=11 continuous, 2-beat bursts with Last -> Grant 01,00,10,00,01; LaneSel 0,1,0.
REQ-042 The bench SHALL cover burst cap: Valid=1 with Last never set -> exactly 8 Ready pulses, then ARB.
REQ-043 The bench SHALL cover supply loss: SupplyGood5478 goes 0 at beat 3 of XFER -> next edge Fault=1, Grant=0, Ready=0, beat 4 not accepted.
REQ-044 The bench SHALL cover reset mid-burst: ResetN=0 at beat 2 -> all outputs 0 the next cycle; after release with Enable=1, full bring-up repeats and the first grant has LaneSel=0.
